// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Iterative 32-bit multiply/divide unit feeding the HI/LO registers.
//            MULT/MULTU use shift-add and DIV/DIVU use restoring division.
//            Both run on operand magnitudes, with one radix-2 step per cycle.
//            A final FIX cycle applies the sign correction. The fixed latency
//            is 34 cycles from the start edge to the HI/LO write edge.
// Ports    : clk          - clock, rising edge
//            reset        - synchronous active-high reset
//            start        - request a new operation (honoured only in IDLE)
//            op[1:0]      - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//            a[31:0]      - multiplicand / dividend
//            b[31:0]      - multiplier / divisor
//            flush        - cancel the in-flight operation
//            busy         - unit not idle
//            done         - one-cycle completion pulse (masked by flush)
//            hi_d, lo_d   - registered data for the HI / LO registers
//            hi_we, lo_we - HI / LO write enables (equal to done)
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_d,
  output logic [31:0] lo_d,
  output logic        hi_we,
  output logic        lo_we
);

  localparam logic [1:0] C_OP_MULT = 2'b00;
  localparam logic [1:0] C_OP_DIV  = 2'b10;
  localparam logic [5:0] C_LAST    = 6'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;        // |a| for signed ops, else a
  logic [31:0] b_q, b_d;        // |b| for signed ops, else b
  logic        sa_q, sa_d;      // sign of a (signed ops only)
  logic        sb_q, sb_d;      // sign of b (signed ops only)
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;    // product, or quotient in [31:0] for divide
  logic [31:0] rem_q, rem_d;    // partial remainder
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;

  // Operand magnitudes captured at start.
  logic        w_signed;
  logic [31:0] w_a_mag, w_b_mag;
  assign w_signed = ~op[0];
  assign w_a_mag  = (w_signed && a[31]) ? (32'd0 - a) : a;
  assign w_b_mag  = (w_signed && b[31]) ? (32'd0 - b) : b;

  // Shift-add step: add the multiplicand into the upper half if the current
  // multiplier bit (acc[0]) is set, then shift right with the carry.
  logic [32:0] w_mul_sum;
  assign w_mul_sum = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? a_q : 32'd0)};

  // Restoring step. The remainder is always below the divisor, so the
  // subtraction result fits in 32 bits whenever the trial value is >= b.
  logic [32:0] w_div_t;
  logic        w_div_ge;
  logic [31:0] w_div_sub;
  assign w_div_t   = {rem_q, acc_q[31]};
  assign w_div_ge  = (w_div_t >= {1'b0, b_q});
  assign w_div_sub = w_div_t[31:0] - b_q;

  // Sign correction applied in FIX.
  logic [63:0] w_prod;
  logic [31:0] w_quot, w_rem, w_a_orig;
  logic        w_div_zero;
  assign w_prod     = ((op_q == C_OP_MULT) && (sa_q ^ sb_q)) ? (64'd0 - acc_q) : acc_q;
  assign w_quot     = ((op_q == C_OP_DIV) && (sa_q ^ sb_q)) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
  assign w_rem      = ((op_q == C_OP_DIV) && sa_q) ? (32'd0 - rem_q) : rem_q;
  assign w_a_orig   = sa_q ? (32'd0 - a_q) : a_q;
  assign w_div_zero = (b_q == 32'd0);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;

    case (state_q)
      S_IDLE: begin
        // flush outranks start: a coincident start is dropped.
        if (!flush && start) begin
          op_d    = op;
          a_d     = w_a_mag;
          b_d     = w_b_mag;
          sa_d    = w_signed && a[31];
          sb_d    = w_signed && b[31];
          cnt_d   = 6'd0;
          rem_d   = 32'd0;
          // Multiply shifts the multiplier out of the low half. Divide
          // shifts the dividend out of the low half and the quotient in.
          acc_d   = {32'd0, (op[1] ? w_a_mag : w_b_mag)};
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[1]) begin
            rem_d = w_div_ge ? w_div_sub : w_div_t[31:0];
            acc_d = {acc_q[63:32], acc_q[30:0], w_div_ge};
          end else begin
            acc_d = {w_mul_sum, acc_q[31:1]};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == C_LAST) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (!op_q[1]) begin
            res_hi_d = w_prod[63:32];
            res_lo_d = w_prod[31:0];
          end else if (w_div_zero) begin
            // Divide by zero returns the raw dividend and an all-ones quotient.
            res_hi_d = w_a_orig;
            res_lo_d = 32'hFFFF_FFFF;
          end else begin
            res_hi_d = w_rem;
            res_lo_d = w_quot;
          end
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= 2'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      rem_q    <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE) && !flush;
  assign hi_we = done;
  assign lo_we = done;
  assign hi_d  = res_hi_q;
  assign lo_d  = res_lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Purpose  : Directed self-checking bench for mult_div_unit. It checks the
//            arithmetic results, the 34-cycle latency, start filtering, and
//            flush/reset cancellation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  localparam logic [1:0] C_MULT  = 2'b00;
  localparam logic [1:0] C_MULTU = 2'b01;
  localparam logic [1:0] C_DIV   = 2'b10;
  localparam logic [1:0] C_DIVU  = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op_s;
  logic [31:0] a_s;
  logic [31:0] b_s;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi_d;
  logic [31:0] lo_d;
  logic        hi_we;
  logic        lo_we;

  int r_checks = 0;
  int r_errors = 0;

  always #5 clk = ~clk;

  mult_div_unit u_dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op_s),
    .a     (a_s),
    .b     (b_s),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi_d  (hi_d),
    .lo_d  (lo_d),
    .hi_we (hi_we),
    .lo_we (lo_we)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    r_checks++;
    if (got !== exp) begin
      r_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present an operation for one cycle. The task returns at the negedge
  // after the accept edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    op_s  = o;
    a_s   = x;
    b_s   = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges after the accept edge until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
    int lat;
    issue(o, x, y);
    check({tag, "_busy"}, busy, 1);
    wait_done(lat);
    check({tag, "_lat"}, lat, 33);
    check({tag, "_hi"}, hi_d, ehi);
    check({tag, "_lo"}, lo_d, elo);
    check({tag, "_we"}, {hi_we, lo_we}, 2'b11);
    @(negedge clk);
    check({tag, "_pulse"}, {done, busy}, 2'b00);
  endtask

  initial begin
    int lat;
    int we_cnt;
    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op_s  = 2'b00;
    a_s   = 32'd0;
    b_s   = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {busy, done, hi_we, lo_we}, 4'b0000);
    check("rst_data", {hi_d, lo_d}, 64'd0);
    reset = 1'b0;

    run_op("multu_max", C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  C_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("mult_min",  C_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("div_neg",   C_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negb",  C_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu_100",  C_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);
    run_op("div_ovf",   C_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_zero", C_DIVU,  32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF);
    run_op("div_zero",  C_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // Starts while busy or in DONE are ignored, and operand changes
    // after the accept edge have no effect.
    issue(C_DIVU, 32'd1000, 32'd3);
    lat = 0;
    while (!done && lat < 40) begin
      if (lat == 4) begin
        start = 1'b1;
        op_s  = C_MULTU;
        a_s   = 32'd5;
        b_s   = 32'd1;
      end else if (lat == 5) begin
        start = 1'b0;
        a_s   = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      lat++;
    end
    check("ign_lat", lat, 33);
    check("ign_hi", hi_d, 32'd1);
    check("ign_lo", lo_d, 32'd333);
    start = 1'b1;
    op_s  = C_DIVU;
    a_s   = 32'd50;
    b_s   = 32'd5;
    @(negedge clk);
    check("done_start_ignored", busy, 0);
    @(negedge clk);
    start = 1'b0;
    check("idle_start_accepted", busy, 1);
    wait_done(lat);
    check("next_lat", lat, 33);
    check("next_res", {hi_d, lo_d}, {32'd0, 32'd10});
    @(negedge clk);

    // A flush in CALC cancels the operation with no write.
    issue(C_MULTU, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_calc_idle", busy, 0);
    we_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      we_cnt += int'(hi_we) + int'(lo_we);
    end
    check("flush_calc_nowe", we_cnt, 0);
    check("flush_calc_hold", {hi_d, lo_d}, {32'd0, 32'd10});

    // A flush in DONE masks the write enables.
    issue(C_MULTU, 32'd6, 32'd7);
    wait_done(lat);
    check("fd_lat", lat, 33);
    flush = 1'b1;
    #1;
    check("fd_mask", {done, hi_we, lo_we}, 3'b000);
    check("fd_busy", busy, 1);
    @(negedge clk);
    flush = 1'b0;
    check("fd_idle", busy, 0);

    // flush together with start in IDLE drops the start.
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    op_s  = C_MULTU;
    a_s   = 32'd2;
    b_s   = 32'd2;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("flush_start_drop", busy, 0);

    // A reset mid-CALC clears everything; the next operation still works.
    issue(C_DIVU, 32'd100, 32'd7);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_ctrl", {busy, done, hi_we, lo_we}, 4'b0000);
    check("rst_mid_data", {hi_d, lo_d}, 64'd0);
    run_op("after_rst", C_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    $display("Simulation finished: %0d checks, %0d errors", r_checks, r_errors);
    $finish;
  end

endmodule
`default_nettype wire
